// File: rtl/lut_cfg_loader_if.sv
// Word stream into the LUT configuration loader: the producer drives data/valid,
// the loader answers with ready.
interface lut_cfg_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/lut_cfg_loader.sv
// Serialises configuration words onto the LUT configuration chain, LSB first.
// Defining CFG_READBACK_EN adds capture of the chain tail into readback words.
module lut_cfg_loader #(
  parameter int CONFIG_WIDTH = 1,
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_BITS   = 16
) (
  input  logic                    config_clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  lut_cfg_loader_if.slave         word_if,
  output logic                    config_en_o,
  output logic [CONFIG_WIDTH-1:0] config_out_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef CFG_READBACK_EN
  ,
  input  logic [CONFIG_WIDTH-1:0] chain_tail_i,
  output logic [WORD_WIDTH-1:0]   rb_word_o,
  output logic                    rb_valid_o
`endif
);

  localparam int CNT_MAX = (CHAIN_BITS > WORD_WIDTH) ? CHAIN_BITS : WORD_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CW_C = CNT_W'(CONFIG_WIDTH);
  localparam logic [CNT_W-1:0] WW_C = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CB_C = CNT_W'(CHAIN_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        word_left_q, word_left_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic                    config_en_q, config_en_d;
  logic [CONFIG_WIDTH-1:0] config_out_q, config_out_d;
  logic                    word_ready_q, word_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept_s;

  function automatic logic [CNT_W-1:0] min_len(input logic [CNT_W-1:0] rem);
    return (rem < WW_C) ? rem : WW_C;
  endfunction

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    word_left_d  = word_left_q;
    remaining_d  = remaining_q;
    accept_s     = word_ready_q && word_if.word_valid;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_FETCH;
          remaining_d = CB_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (accept_s) begin
          shreg_d     = word_if.word_data;
          word_left_d = min_len(remaining_q);
          state_d     = ST_SHIFT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        remaining_d = remaining_q - CW_C;
        if (remaining_q == CW_C) begin
          state_d     = ST_DONE;
          word_left_d = {CNT_W{1'b0}};
        end else if (word_left_q == CW_C) begin
          // Current word exhausted: a prefetched word keeps the chain moving without a bubble.
          if (accept_s) begin
            shreg_d     = word_if.word_data;
            word_left_d = min_len(remaining_q - CW_C);
          end else begin
            state_d     = ST_FETCH;
            word_left_d = {CNT_W{1'b0}};
          end
        end else begin
          shreg_d     = shreg_q >> CONFIG_WIDTH;
          word_left_d = word_left_q - CW_C;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    config_en_d  = (state_d == ST_SHIFT);
    config_out_d = config_en_d ? shreg_d[CONFIG_WIDTH-1:0] : {CONFIG_WIDTH{1'b0}};
    word_ready_d = (state_d == ST_FETCH) ||
                   ((state_d == ST_SHIFT) && (word_left_d == CW_C) && (remaining_d > CW_C));
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge config_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= {WORD_WIDTH{1'b0}};
      word_left_q  <= {CNT_W{1'b0}};
      remaining_q  <= {CNT_W{1'b0}};
      config_en_q  <= 1'b0;
      config_out_q <= {CONFIG_WIDTH{1'b0}};
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      word_left_q  <= word_left_d;
      remaining_q  <= remaining_d;
      config_en_q  <= config_en_d;
      config_out_q <= config_out_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_if.word_ready = word_ready_q;
  assign config_en_o        = config_en_q;
  assign config_out_o       = config_out_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

`ifdef CFG_READBACK_EN
  localparam int RB_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] rb_acc_q, rb_acc_d;
  logic [RB_W-1:0]       rb_cnt_q, rb_cnt_d;
  logic [WORD_WIDTH-1:0] rb_word_q, rb_word_d;
  logic                  rb_valid_q, rb_valid_d;
  logic [WORD_WIDTH-1:0] rb_merge_s;
  logic                  rb_emit_s;

  // config_en_q is high exactly in SHIFT, so remaining_q marks the final shift here.
  always_comb begin
    rb_acc_d   = rb_acc_q;
    rb_cnt_d   = rb_cnt_q;
    rb_word_d  = rb_word_q;
    rb_valid_d = 1'b0;
    rb_merge_s = rb_acc_q | (WORD_WIDTH'(chain_tail_i) << rb_cnt_q);
    rb_emit_s  = ((rb_cnt_q + RB_W'(CONFIG_WIDTH)) == RB_W'(WORD_WIDTH)) || (remaining_q == CW_C);
    if (config_en_q) begin
      if (rb_emit_s) begin
        rb_word_d  = rb_merge_s;
        rb_valid_d = 1'b1;
        rb_acc_d   = {WORD_WIDTH{1'b0}};
        rb_cnt_d   = {RB_W{1'b0}};
      end else begin
        rb_acc_d = rb_merge_s;
        rb_cnt_d = rb_cnt_q + RB_W'(CONFIG_WIDTH);
      end
    end else begin
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge config_clk) begin
    if (!rst_n) begin
      rb_acc_q   <= {WORD_WIDTH{1'b0}};
      rb_cnt_q   <= {RB_W{1'b0}};
      rb_word_q  <= {WORD_WIDTH{1'b0}};
      rb_valid_q <= 1'b0;
    end else begin
      rb_acc_q   <= rb_acc_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_word_q  <= rb_word_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_word_o  = rb_word_q;
  assign rb_valid_o = rb_valid_q;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomised bench for lut_cfg_loader: a bit-queue model of the load plus a behavioural
// LUT chain driven by the loader; readback is modelled when CFG_READBACK_EN is defined.
module tb_lut_cfg_loader;
  localparam int CW    = 2;
  localparam int WW    = 8;
  localparam int CHAIN = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          cfg_en;
  logic [CW-1:0] cfg_out;
  logic          busy;
  logic          done;
`ifdef CFG_READBACK_EN
  logic [CW-1:0] chain_tail;
  logic [WW-1:0] rb_word;
  logic          rb_valid;
  bit            rb_bits[$];
  logic [WW-1:0] rb_hold;
  bit            rb_pend;
`endif

  lut_cfg_loader_if #(.WORD_WIDTH(WW)) bus ();

  lut_cfg_loader #(
    .CONFIG_WIDTH(CW),
    .WORD_WIDTH(WW),
    .CHAIN_BITS(CHAIN)
  ) dut (
    .config_clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .word_if(bus),
    .config_en_o(cfg_en),
    .config_out_o(cfg_out),
    .busy_o(busy),
    .done_o(done)
`ifdef CFG_READBACK_EN
    ,
    .chain_tail_i(chain_tail),
    .rb_word_o(rb_word),
    .rb_valid_o(rb_valid)
`endif
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             failures = 0;
  bit             bitq[$];
  bit             in_load = 1'b0;
  bit             acc_flag = 1'b0;
  int             fetched = 0;
  int             gap = 0;
  logic [CHAIN-1:0] chain;
  logic [CHAIN-1:0] img;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model for the next edge.
  task automatic step(input bit do_start, input bit do_rst);
    bit            en_e, rdy_e, done_e, busy_b;
    logic [CW-1:0] out_e;
    int            n;
    @(negedge clk);
`ifdef CFG_READBACK_EN
    chain_tail = chain[CW-1:0];
    check_eq("rb_valid", rb_valid, rb_pend);
    check_eq("rb_word", rb_word, rb_hold);
`endif
    busy_b = in_load;
    en_e   = in_load && (bitq.size() > 0);
    rdy_e  = in_load && (fetched < CHAIN) && (bitq.size() <= CW);
    done_e = in_load && (fetched == CHAIN) && (bitq.size() == 0);
    out_e  = '0;
    if (en_e) begin
      for (int i = 0; i < CW; i++) out_e[i] = bitq[i];
    end
    check_eq("config_en", cfg_en, en_e);
    check_eq("config_out", cfg_out, out_e);
    check_eq("word_ready", bus.word_ready, rdy_e);
    check_eq("busy", busy, busy_b);
    check_eq("done", done, done_e);
    if (done_e) check_eq("chain_image", chain, img);

    if (acc_flag) begin
      bus.word_valid = 1'b0;
      acc_flag = 1'b0;
    end
    if (!bus.word_valid) begin
      if (gap == 0) begin
        bus.word_valid = 1'b1;
        bus.word_data  = WW'($urandom);
      end else begin
        gap--;
      end
    end
    start_i = do_start;
    rst_n   = !do_rst;

    if (cfg_en) chain = {cfg_out, chain[CHAIN-1:CW]};
`ifdef CFG_READBACK_EN
    rb_pend = 1'b0;
    if (do_rst) begin
      rb_bits.delete();
      rb_hold = '0;
    end else if (en_e) begin
      for (int i = 0; i < CW; i++) rb_bits.push_back(chain_tail[i]);
      if (rb_bits.size() == WW || (fetched == CHAIN && bitq.size() == CW)) begin
        rb_hold = '0;
        for (int i = 0; i < rb_bits.size(); i++) rb_hold[i] = rb_bits[i];
        rb_pend = 1'b1;
        rb_bits.delete();
      end
    end
`endif
    if (do_rst) begin
      in_load = 1'b0;
      bitq.delete();
      fetched = 0;
    end else begin
      if (en_e) repeat (CW) void'(bitq.pop_front());
      if (rdy_e && bus.word_valid) begin
        n = (CHAIN - fetched < WW) ? CHAIN - fetched : WW;
        for (int i = 0; i < n; i++) begin
          bitq.push_back(bus.word_data[i]);
          img[fetched + i] = bus.word_data[i];
        end
        fetched += n;
        acc_flag = 1'b1;
        gap = $urandom_range(0, 3);
      end
      if (done_e) in_load = 1'b0;
      if (do_start && !busy_b) begin
        in_load = 1'b1;
        fetched = 0;
        img     = '0;
      end
    end
  endtask

  initial begin
    int rst_at;
    int cyc;
    rst_n          = 1'b0;
    start_i        = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    chain          = 20'h000FF;
    img            = '0;
`ifdef CFG_READBACK_EN
    chain_tail = '0;
    rb_hold    = '0;
    rb_pend    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    for (int l = 0; l < 40; l++) begin
      rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1;
      cyc = 0;
      step(1'b1, 1'b0);
      while (in_load && cyc < 200) begin
        step($urandom_range(0, 7) == 0, cyc == rst_at);
        cyc++;
      end
      check_eq("load_complete", in_load, 1'b0);
      if (in_load) step(1'b0, 1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
